// File: rtl/bram_access_arbiter_if.sv
// rtl/bram_access_arbiter_if.sv - Wishbone slave window bundle for the BRAM access arbiter
//
// Groups the Wishbone slave signals (strobe/cycle/write, byte enables,
// byte address, write data, acknowledge, read data).
//   master : firmware side, drives the request fields, receives ack/data
//   slave  : arbiter side, receives the request fields, drives ack/data
interface bram_access_arbiter_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/bram_access_arbiter.sv
// rtl/bram_access_arbiter.sv - round-robin arbiter sharing a fixed-latency single-port BRAM
//
// Two requesters (Wishbone window at BASE and the local engine port) share
// one BRAM. Each access is latched on grant, the BRAM is held enabled for
// DELAYS cycles, read data is captured on the last HOLD cycle and returned
// with a one-cycle ack in RESP.
//   wb_clk_i, wb_rst_i   : clock, asynchronous active-high reset
//   wbs                  : Wishbone slave window (interface, slave modport)
//   eng_*                : engine request / acknowledge / data port
//   bram_en/we/a/di/do   : BRAM pins (word address, zero-extended)
//   busy                 : high while an access is in HOLD or RESP
module bram_access_arbiter #(
    parameter int         DELAYS = 10,
    parameter int         AW     = 22,
    parameter logic [7:0] BASE   = 8'h38
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    bram_access_arbiter_if.slave  wbs,
    input  logic                  eng_req,
    input  logic                  eng_we,
    input  logic [3:0]            eng_sel,
    input  logic [AW-1:0]         eng_addr,
    input  logic [31:0]           eng_wdata,
    output logic                  eng_ack,
    output logic [31:0]           eng_rdata,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [31:0]           bram_a,
    output logic [31:0]           bram_di,
    input  logic [31:0]           bram_do,
    output logic                  busy
);

    localparam int          CW       = $clog2(DELAYS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DELAYS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_WB  = 1'b0,
        OWN_ENG = 1'b1
    } owner_t;

    state_t          state, state_d;
    owner_t          owner_q, last_grant;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;

    logic            wb_req;
    logic            grant_wb;
    logic            grant_eng;

    // Low address bits and the window decode bits above the word field are
    // not part of the BRAM word address; fold them into a sink.
    logic            unused_adr;
    assign unused_adr = ^wbs.wbs_adr_i;

    assign wb_req = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:24] == BASE);

    always_comb begin
        state_d   = state;
        grant_wb  = 1'b0;
        grant_eng = 1'b0;
        case (state)
            IDLE: begin
                if (wb_req && eng_req) begin
                    // Tie: the side that did not win last time goes first.
                    if (last_grant == OWN_WB) grant_eng = 1'b1;
                    else                      grant_wb  = 1'b1;
                end else if (wb_req) begin
                    grant_wb = 1'b1;
                end else if (eng_req) begin
                    grant_eng = 1'b1;
                end
                if (grant_wb || grant_eng) state_d = HOLD;
            end
            HOLD: begin
                if (cnt == LAST_CNT) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 4'h0;
        bram_a    = 32'h0;
        bram_di   = 32'h0;
        busy      = 1'b0;
        wbs.wbs_ack_o = 1'b0;
        wbs.wbs_dat_o = 32'h0;
        eng_ack   = 1'b0;
        eng_rdata = 32'h0;
        if (state == HOLD) begin
            bram_en = 1'b1;
            bram_we = we_q ? sel_q : 4'h0;
            bram_a  = {{(32-AW){1'b0}}, addr_q};
            bram_di = wdata_q;
            busy    = 1'b1;
        end
        if (state == RESP) begin
            busy = 1'b1;
            if (owner_q == OWN_WB) begin
                wbs.wbs_ack_o = 1'b1;
                wbs.wbs_dat_o = rdata_q;
            end else begin
                eng_ack   = 1'b1;
                eng_rdata = rdata_q;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner_q    <= OWN_WB;
            last_grant <= OWN_ENG;
            cnt        <= '0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            state <= state_d;
            if (grant_wb) begin
                owner_q    <= OWN_WB;
                last_grant <= OWN_WB;
                we_q       <= wbs.wbs_we_i;
                sel_q      <= wbs.wbs_sel_i;
                addr_q     <= wbs.wbs_adr_i[AW+1:2];
                wdata_q    <= wbs.wbs_dat_i;
                cnt        <= '0;
            end else if (grant_eng) begin
                owner_q    <= OWN_ENG;
                last_grant <= OWN_ENG;
                we_q       <= eng_we;
                sel_q      <= eng_sel;
                addr_q     <= eng_addr;
                wdata_q    <= eng_wdata;
                cnt        <= '0;
            end else if (state == HOLD) begin
                cnt <= cnt + CW'(1);
                if (cnt == LAST_CNT) rdata_q <= we_q ? 32'h0 : bram_do;
            end
        end
    end

endmodule

// File: tb/tb_bram_access_arbiter.sv
// tb/tb_bram_access_arbiter.sv - scoreboard bench for bram_access_arbiter
module tb_bram_access_arbiter;
    localparam int DELAYS = 10;
    localparam int AW     = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bram_access_arbiter_if wbs_if();

    logic          eng_req   = 1'b0;
    logic          eng_we    = 1'b0;
    logic [3:0]    eng_sel   = 4'h0;
    logic [AW-1:0] eng_addr  = '0;
    logic [31:0]   eng_wdata = 32'h0;
    logic          eng_ack;
    logic [31:0]   eng_rdata;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [31:0]   bram_a;
    logic [31:0]   bram_di;
    logic [31:0]   bram_do;
    logic          busy;

    bram_access_arbiter #(.DELAYS(DELAYS), .AW(AW), .BASE(8'h38)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (wbs_if),
        .eng_req  (eng_req),
        .eng_we   (eng_we),
        .eng_sel  (eng_sel),
        .eng_addr (eng_addr),
        .eng_wdata(eng_wdata),
        .eng_ack  (eng_ack),
        .eng_rdata(eng_rdata),
        .bram_en  (bram_en),
        .bram_we  (bram_we),
        .bram_a   (bram_a),
        .bram_di  (bram_di),
        .bram_do  (bram_do),
        .busy     (busy)
    );

    // BRAM stand-in: byte-enabled write while enabled, combinational read.
    logic [31:0] bram_mem [0:255];
    assign bram_do = bram_en ? bram_mem[bram_a[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram_mem[bram_a[7:0]][b*8 +: 8] <= bram_di[b*8 +: 8];
        end
    end

    // Reference model: accesses are served one at a time in grant order.
    logic [31:0] ref_mem [0:255];
    bit          ref_last_eng = 1'b1;

    typedef struct {
        bit          is_eng;
        bit          we;
        logic [3:0]  sel;
        int          word;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          exp_cyc;
    } exp_t;

    typedef struct {
        bit          we;
        logic [3:0]  sel;
        int          word;
        logic [31:0] wdata;
    } op_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic exp_t model_op(bit is_eng, op_t op, int exp_cyc);
        exp_t e;
        e.is_eng  = is_eng;
        e.we      = op.we;
        e.sel     = op.sel;
        e.word    = op.word;
        e.wdata   = op.wdata;
        e.exp_cyc = exp_cyc;
        if (op.we) begin
            for (int b = 0; b < 4; b++)
                if (op.sel[b]) ref_mem[op.word][b*8 +: 8] = op.wdata[b*8 +: 8];
            e.rdata = 32'h0;
        end else begin
            e.rdata = ref_mem[op.word];
        end
        ref_last_eng = is_eng;
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.we    = 1'($urandom_range(0, 1));
        o.sel   = 4'($urandom_range(1, 15));
        o.word  = int'($urandom_range(0, 15));
        o.wdata = $urandom;
        return o;
    endfunction

    // Monitor: pops the scoreboard on every ack, checks BRAM pins during HOLD.
    int en_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                en_cnt = 0;
            end else begin
                if (wbs_if.wbs_ack_o || eng_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", {wbs_if.wbs_ack_o, eng_ack}, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_owner", {30'h0, wbs_if.wbs_ack_o, eng_ack},
                            e.is_eng ? 32'h1 : 32'h2);
                        chk("ack_data", e.is_eng ? eng_rdata : wbs_if.wbs_dat_o, e.rdata);
                        chk("other_data", e.is_eng ? wbs_if.wbs_dat_o : eng_rdata, 32'h0);
                        chk("ack_cycle", cyc, e.exp_cyc);
                        chk("hold_len", en_cnt, DELAYS);
                        chk("busy_resp", {31'h0, busy}, 32'h1);
                        chk("en_resp", {31'h0, bram_en}, 32'h0);
                    end
                    en_cnt = 0;
                end else begin
                    chk("idle_dat", wbs_if.wbs_dat_o | eng_rdata, 32'h0);
                end
                if (bram_en) begin
                    en_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_en", {31'h0, bram_en}, 32'h0);
                    end else begin
                        chk("bram_a", bram_a, 32'(exp_q[0].word));
                        chk("bram_we", {28'h0, bram_we}, exp_q[0].we ? {28'h0, exp_q[0].sel} : 32'h0);
                        if (exp_q[0].we) chk("bram_di", bram_di, exp_q[0].wdata);
                        chk("busy_hold", {31'h0, busy}, 32'h1);
                    end
                end
            end
        end
    end

    task automatic set_wb(bit req, op_t op);
        wbs_if.wbs_stb_i = req;
        wbs_if.wbs_cyc_i = req;
        wbs_if.wbs_we_i  = op.we;
        wbs_if.wbs_sel_i = op.sel;
        wbs_if.wbs_adr_i = 32'h3800_0000 + 32'(op.word) * 4;
        wbs_if.wbs_dat_i = op.wdata;
    endtask

    task automatic set_eng(bit req, op_t op);
        eng_req   = req;
        eng_we    = op.we;
        eng_sel   = op.sel;
        eng_addr  = AW'(op.word);
        eng_wdata = op.wdata;
    endtask

    task automatic wait_ack(bit is_eng);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_eng ? eng_ack : wbs_if.wbs_ack_o) && n < 200);
        if (n >= 200) chk(is_eng ? "eng_ack_timeout" : "wb_ack_timeout", 32'h0, 32'h1);
    endtask

    // Single uncontended access; returns one idle cycle after the ack.
    task automatic single(bit is_eng, bit we, logic [3:0] sel, int word, logic [31:0] dat);
        op_t o;
        o.we = we; o.sel = sel; o.word = word; o.wdata = dat;
        exp_q.push_back(model_op(is_eng, o, cyc + DELAYS + 1));
        if (is_eng) set_eng(1'b1, o); else set_wb(1'b1, o);
        wait_ack(is_eng);
        if (is_eng) set_eng(1'b0, o); else set_wb(1'b0, o);
        @(negedge clk);
    endtask

    // Both sides request continuously for n accesses each.
    task automatic contend(int n);
        op_t wl[$];
        op_t el[$];
        int  c = cyc;
        bit  first_eng = !ref_last_eng;
        for (int i = 0; i < n; i++) begin
            wl.push_back(rand_op());
            el.push_back(rand_op());
        end
        for (int k = 0; k < 2 * n; k++) begin
            bit is_eng = first_eng ^ bit'(k % 2);
            exp_q.push_back(model_op(is_eng, is_eng ? el[k/2] : wl[k/2],
                                     c + (k + 1) * (DELAYS + 2) - 1));
        end
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    set_wb(1'b1, wl[i]);
                    wait_ack(1'b0);
                end
                set_wb(1'b0, wl[n-1]);
            end
            begin
                for (int j = 0; j < n; j++) begin
                    set_eng(1'b1, el[j]);
                    wait_ack(1'b1);
                end
                set_eng(1'b0, el[n-1]);
            end
        join
        @(negedge clk);
    endtask

    task automatic chk_all_zero(string name);
        chk(name, {29'h0, bram_en, busy, wbs_if.wbs_ack_o | eng_ack}, 32'h0);
        chk({name, "_dat"}, wbs_if.wbs_dat_o | eng_rdata, 32'h0);
        chk({name, "_bram"}, bram_a | bram_di | {28'h0, bram_we}, 32'h0);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        op_t o;
        int  word_ab;
        for (int i = 0; i < 256; i++) begin
            bram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        o.we = 1'b0; o.sel = 4'h0; o.word = 0; o.wdata = 32'h0;
        set_wb(1'b0, o);
        set_eng(1'b0, o);

        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst = 1'b0;
        ref_last_eng = 1'b1;
        @(negedge clk);

        // Simultaneous requests right after reset: WB first, then alternation.
        contend(4);

        single(1'b0, 1'b1, 4'hF, 4, 32'hDEAD_BEEF);
        single(1'b0, 1'b0, 4'hF, 4, 32'h0);
        single(1'b0, 1'b1, 4'h1, 4, 32'h0000_00AA);
        single(1'b0, 1'b0, 4'hF, 4, 32'h0);
        single(1'b1, 1'b1, 4'hF, 5, 32'h1234_5678);
        single(1'b0, 1'b0, 4'hF, 5, 32'h0);

        for (int i = 0; i < 24; i++) begin
            o = rand_op();
            single(1'($urandom_range(0, 1)), o.we, o.sel, o.word, o.wdata);
        end

        contend(5);

        // Access outside the window is never granted.
        wbs_if.wbs_stb_i = 1'b1;
        wbs_if.wbs_cyc_i = 1'b1;
        wbs_if.wbs_we_i  = 1'b0;
        wbs_if.wbs_adr_i = 32'h3000_0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("out_of_window", {29'h0, wbs_if.wbs_ack_o, bram_en, busy}, 32'h0);
        end
        wbs_if.wbs_stb_i = 1'b0;
        wbs_if.wbs_cyc_i = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write's HOLD phase (cnt == 4).
        word_ab = 40;
        o.we = 1'b1; o.sel = 4'hF; o.word = word_ab; o.wdata = 32'hCAFE_F00D;
        exp_q.push_back(model_op(1'b0, o, cyc + DELAYS + 1));
        set_wb(1'b1, o);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        set_wb(1'b0, o);
        exp_q.delete();
        ref_last_eng = 1'b1;
        @(negedge clk);
        chk_all_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        single(1'b0, 1'b0, 4'hF, 5, 32'h0);
        single(1'b1, 1'b0, 4'hF, 4, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bram_access_arbiter.md
Name: bram_access_arbiter

Overview:
- Shares the single-port user BRAM (fixed access latency) between two requesters: the Wishbone slave window at 0x38xx_xxxx, driven by firmware, and a local engine port, driven by the FIR data mover.
- Sits between the Wishbone bus, the engine and the `bram` instance. It owns the BRAM enable/address/data pins and sequences every access with a fixed-latency counter.
- Ties are resolved round-robin.

Parameters:
- DELAYS, 10: BRAM access latency in cycles, i.e. how long bram_en is held before bram_do is valid; legal range >= 1.
- AW, 22: word-address width of the engine port and of the BRAM address field.
- BASE, 8'h38: value of wbs_adr_i[31:24] that selects the BRAM window.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_stb_i / wbs_cyc_i / wbs_we_i  in  1 each  Wishbone strobe / cycle / write
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack, 0 otherwise
- eng_req  in  1  engine access request, level, held until eng_ack
- eng_we  in  1  engine write
- eng_sel  in  4  engine byte enables
- eng_addr  in  AW  engine word address
- eng_wdata  in  32  engine write data
- eng_ack  out  1  one-cycle acknowledge
- eng_rdata  out  32  read data, valid with eng_ack, 0 otherwise
- bram_en  out  1  BRAM enable
- bram_we  out  4  BRAM byte write enables
- bram_a  out  32  BRAM word address, zero-extended from AW bits
- bram_di  out  32  BRAM write data
- bram_do  in  32  BRAM read data
- busy  out  1  high in HOLD and RESP

Behaviour:
- wb_req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24]==BASE). The Wishbone word address is wbs_adr_i[AW+1:2].
- Reset values: all outputs 0; state IDLE; cnt 0; last_grant = ENG, so Wishbone wins the first tie.
- FSM state IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that is not last_grant.
  - On grant: latch owner, we, sel, address and wdata into registers; update last_grant; clear cnt; go to HOLD.
- FSM state HOLD:
  - Outputs: bram_en=1, bram_a and bram_di from the latched registers, bram_we = latched we ? latched sel : 0. The write is held for the whole HOLD phase and is idempotent.
  - cnt increments each cycle.
  - When cnt==DELAYS-1: capture bram_do into rdata_q (0 for writes) and go to RESP.
- FSM state RESP:
  - bram_en=0, bram_we=0.
  - Owner's ack=1 for exactly this cycle, with its dat output = rdata_q. The other requester's ack and data stay 0.
  - Go to IDLE.
- Latency: a request first seen in cycle 0 (IDLE) is acked in cycle DELAYS+1. Minimum spacing between grants is DELAYS+2 cycles.
- The requester not granted keeps waiting; its inputs are ignored until it is granted. There is no starvation: continuous contention alternates WB, ENG, WB, ENG.
- Request dropped during HOLD: the access still completes and the ack still pulses in RESP (master protocol violation; not filtered).
- Wishbone access outside BASE: never granted, no ack, bram_en stays 0. Another decoder owns it.
- Latched values are frozen for the whole access. Changes on the inputs during HOLD have no effect.
- Reset mid-operation, asynchronous: immediately return to IDLE with all outputs 0. An in-flight write may be partially applied. No ack is issued for an aborted access.
- Counter width: clog2(DELAYS+1). No wrap, since cnt is cleared on every grant.

Test Plan:
- WB write 0xDEADBEEF to 0x3800_0010, sel=4'hF, then read the same address -> each ack high exactly one cycle at cycle DELAYS+1 (11) after the request; read wbs_dat_o=0xDEADBEEF, 0 in all other cycles; bram_a=0x4 during HOLD.
- Byte write: WB writes 0x000000AA with sel=4'b0001 to the same address, then reads it -> 0xDEADBEAA.
- eng_req and WB raised in the same cycle after reset -> WB acked at cycle 11, engine acked at cycle 23. Holding both continuously thereafter -> grant order WB, ENG, WB, ENG with no gaps beyond DELAYS+2.
- Engine writes eng_addr=0x5 data 0x12345678, then WB reads 0x3800_0014 -> 0x12345678.
- WB access to 0x3000_0000 -> no wbs_ack_o for 20 cycles; bram_en stays 0; busy stays 0.
- Assert wb_rst_i during HOLD (cnt=4) -> bram_en, busy, acks and dat outputs are 0 the same cycle. After release, a new WB read completes normally at cycle DELAYS+1.
